pcie_dll_rx_seq_checker: RTL and testbench
==========================================

# pcie_dll_rx_seq_checker

Receive-side data link layer check for TLPs arriving from the physical layer. It strips and checks the 12-bit sequence number and the 32-bit LCRC, and forwards good TLP bodies to the transaction layer. It also raises ACK/NAK requests for the DLLP transmitter. It sits between the `phy2tlp` stream and the transaction-layer `tlp` output, and is the counterpart of the TX sequence/LCRC stamping path.

## Interface
- `DATA_WIDTH`, 32: stream width. Only 32 is supported.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `USER_WIDTH`, 4: tuser width. Bit 0 of the output carries the discard flag.
- `ACK_COALESCE`, 4: number of good TLPs that forces an ACK request.
- `ACK_TIMEOUT`, 255: cycles after the first un-ACKed good TLP before an ACK request is forced.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Asynchronous, active-high.
- `phy_link_up_i` in 1: link up. While low, the block is held in its reset state; only `s_axis_phy2tlp_tready_o` differs, and it is held at 1.
- `s_axis_phy2tlp_tdata_i`/`tkeep_i`/`tvalid_i`/`tlast_i`/`tuser_i` in 32/4/1/1/4: framed TLP from the PHY.
- `s_axis_phy2tlp_tready_o` out 1.
- `m_axis_tlp_tdata_o`/`tkeep_o`/`tvalid_o`/`tlast_o`/`tuser_o` out 32/4/1/1/4: stripped TLP to the transaction layer.
- `m_axis_tlp_tready_i` in 1.
- `ack_nak_valid_o` out 1: ACK/NAK request pending.
- `ack_nak_type_o` out 1: 0 = ACK, 1 = NAK.
- `ack_nak_seq_o` out 12: AckNak_Seq_Num.
- `ack_nak_ready_i` in 1: DLLP transmitter accepts the request.
- `next_rcv_seq_o` out 12: NEXT_RCV_SEQ, for status.
- `lcrc_err_o`, `seq_err_o` out 1: one-cycle error pulses.

## Operation
- **Frame format:**
  - Beat 0: `tdata[11:0]` = seq; `[31:12]` ignored.
  - Beats 1..N-1: TLP body.
  - Beat N (tlast): LCRC. Minimum frame is 3 beats.
  - All input tkeep must be `4'hF`; tkeep is passed through to the output.
- **LCRC check:** CRC-32 with reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over every byte of beats 0..N-1, with `tdata[7:0]` first within each beat. The frame passes if the received LCRC equals the bitwise NOT of the final CRC register.
- **States:**
  - **HDR:** accepts beat 0.
    - seq == NEXT_RCV_SEQ: go to FWD.
    - seq != NEXT_RCV_SEQ: go to DROP.
    - A 1-beat frame (tlast on the header beat) is dropped, pulses `seq_err_o`, and stays in HDR.
  - **FWD:** beats pass through a one-entry hold register. Each incoming beat pushes out the previously held beat. When the LCRC beat arrives:
    - The held beat is emitted with `tlast=1`.
    - `tuser[0]` = 1 if the LCRC is bad, else 0.
    - The state returns to HDR.
    - The LCRC beat itself is never emitted.
  - **DROP:** consumes beats with tready=1 until tlast, then returns to HDR. Nothing is forwarded.
- **Good TLP:**
  - NEXT_RCV_SEQ increments, wrapping 4095 to 0.
  - The NAK_SCHEDULED flag clears.
  - The ack counter increments.
- **Bad LCRC:** NEXT_RCV_SEQ is unchanged, `lcrc_err_o` pulses, and the forwarded TLP ends with `tuser[0]=1`. If NAK_SCHEDULED is clear, the block requests a NAK with seq = NEXT_RCV_SEQ-1 and sets NAK_SCHEDULED.
- **Sequence mismatch:** `seq_err_o` pulses. Let d = (seq − NEXT_RCV_SEQ) mod 4096.
  - d ≥ 2048 (duplicate): request an ACK with NEXT_RCV_SEQ-1.
  - Otherwise (lost TLP): request a NAK with NEXT_RCV_SEQ-1, unless NAK_SCHEDULED is set.
- **ACK coalescing:** when the ack counter reaches `ACK_COALESCE`, or the timer (started at the first un-ACKed good TLP) reaches `ACK_TIMEOUT`, the block requests an ACK with NEXT_RCV_SEQ-1. The counter and timer clear when that request is accepted.
- **Request register:**
  - Single entry.
  - A new request overwrites a pending one.
  - An ACK never overwrites a pending NAK.
  - `ack_nak_valid_o` clears on `valid & ready`, unless a new request arrives in the same cycle.
- **Input tready:**
  - HDR and DROP: 1.
  - FWD: `!hold_valid | m_axis_tlp_tready_i`.

## Timing
- **Reset values (asynchronous):**
  - Outputs: all 0, except `s_axis_phy2tlp_tready_o` = 1.
  - State: HDR; NEXT_RCV_SEQ = 0; NAK_SCHEDULED = 0; counters = 0.
- **Latency:** output beat k appears one accepted input beat after input beat k+1. The last body beat appears in the cycle after the LCRC beat is accepted.
- **Request timing:** a request is asserted the cycle after the deciding beat (header or LCRC) is accepted. It stays stable while valid and unaccepted, except when overwritten.
- **Output stability:** `m_axis_tlp` data is held stable while valid and not ready.
- **Reset or link-down mid-frame:** the partial output frame is abandoned with no tlast, and the hold register is cleared.

## Test plan
- Three good 4-beat frames with seq 0, 1, 2 and `ACK_COALESCE`=3 → three 2-beat outputs with `tuser[0]`=0, then ACK seq=2; `next_rcv_seq_o`=3.
- Frame seq 0 with LCRC bit 0 flipped → body forwarded with `tuser[0]`=1, NAK seq=4095, `lcrc_err_o` pulse. A second bad frame → no second NAK. Seq 0 good → `next_rcv_seq_o`=1.
- After seq 0..4 good, replay seq 3 → nothing forwarded, ACK seq=4. Send seq 7 → dropped, NAK seq=4. Repeat seq 7 → no new NAK.
- Wrap: preload to 4095 via 4095 good frames (or a faster bench path), seq 4095 good → `next_rcv_seq_o`=0, next ACK seq=4095.
- Output tready toggling 1/0 every cycle on a 10-beat frame → 8 body beats delivered in order, none lost or duplicated.
- Assert `rst_i` mid-FWD, then send seq 0 → state restarts and seq 0 is accepted as good.

Source files
------------

// File: rtl/pcie_dll_rx_seq_checker.sv
// Receive-side DLL checker: strips and checks sequence number and LCRC, forwards good TLP
// bodies, and schedules ACK/NAK requests for the DLLP transmitter.
module pcie_dll_rx_seq_checker #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = 4,
  parameter int unsigned ACK_COALESCE = 4,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  phy_link_up_i,
  input  logic [DATA_WIDTH-1:0] s_axis_phy2tlp_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_phy2tlp_tkeep_i,
  input  logic                  s_axis_phy2tlp_tvalid_i,
  input  logic                  s_axis_phy2tlp_tlast_i,
  input  logic [USER_WIDTH-1:0] s_axis_phy2tlp_tuser_i,
  output logic                  s_axis_phy2tlp_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tlp_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tlp_tkeep_o,
  output logic                  m_axis_tlp_tvalid_o,
  output logic                  m_axis_tlp_tlast_o,
  output logic [USER_WIDTH-1:0] m_axis_tlp_tuser_o,
  input  logic                  m_axis_tlp_tready_i,
  output logic                  ack_nak_valid_o,
  output logic                  ack_nak_type_o,
  output logic [11:0]           ack_nak_seq_o,
  input  logic                  ack_nak_ready_i,
  output logic [11:0]           next_rcv_seq_o,
  output logic                  lcrc_err_o,
  output logic                  seq_err_o
);

  localparam logic [15:0] CoalesceCnt = 16'(ACK_COALESCE);
  localparam logic [15:0] TimeoutCnt  = 16'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StHdr, StFwd, StDrop} state_e;

  state_e                state_q, state_d;
  logic [11:0]           next_seq_q, next_seq_d;
  logic                  nak_sched_q, nak_sched_d;
  logic [31:0]           crc_q, crc_d;
  logic [15:0]           ack_cnt_q, ack_cnt_d;
  logic [15:0]           ack_tmr_q, ack_tmr_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [KEEP_WIDTH-1:0] hold_keep_q, hold_keep_d;
  logic [USER_WIDTH-1:0] hold_user_q, hold_user_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_type_q, req_type_d;
  logic [11:0]           req_seq_q, req_seq_d;
  logic                  lcrc_err_q, lcrc_err_d;
  logic                  seq_err_q, seq_err_d;

  logic        s_tready;
  logic        in_fire;
  logic        req_accept;
  logic        good_tlp;
  logic        new_req;
  logic        new_type;
  logic [11:0] new_seq;
  logic [11:0] rx_seq;
  logic [11:0] seq_dist;
  logic [11:0] prev_seq;

  // Bit-serial CRC-32 over one beat, byte 0 first, LSB first within each byte.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ data[i]}});
    end
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    next_seq_d   = next_seq_q;
    nak_sched_d  = nak_sched_q;
    crc_d        = crc_q;
    ack_cnt_d    = ack_cnt_q;
    ack_tmr_d    = ack_tmr_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_user_d  = hold_user_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    req_valid_d  = req_valid_q;
    req_type_d   = req_type_q;
    req_seq_d    = req_seq_q;
    lcrc_err_d   = 1'b0;
    seq_err_d    = 1'b0;
    good_tlp     = 1'b0;
    new_req      = 1'b0;
    new_type     = 1'b0;
    new_seq      = '0;

    rx_seq     = s_axis_phy2tlp_tdata_i[11:0];
    seq_dist   = rx_seq - next_seq_q;
    prev_seq   = next_seq_q - 12'd1;
    req_accept = req_valid_q & ack_nak_ready_i;

    s_tready = 1'b1;
    if (state_q == StFwd) s_tready = !hold_valid_q | m_axis_tlp_tready_i;
    in_fire = s_axis_phy2tlp_tvalid_i & s_tready;

    if (out_valid_q & m_axis_tlp_tready_i) out_valid_d = 1'b0;

    // Accepted ACK acknowledges everything received so far.
    if (req_accept & !req_type_q) begin
      ack_cnt_d = '0;
      ack_tmr_d = '0;
    end else if (ack_cnt_q != 16'd0 && ack_tmr_q < TimeoutCnt) begin
      ack_tmr_d = ack_tmr_q + 16'd1;
    end

    // Timer ACK has lowest priority; a beat decision below overrides it.
    if (ack_cnt_q != 16'd0 && ack_tmr_q >= TimeoutCnt && !req_valid_q) begin
      new_req = 1'b1;
      new_seq = prev_seq;
    end

    case (state_q)
      StHdr: begin
        if (in_fire) begin
          if (s_axis_phy2tlp_tlast_i) begin
            seq_err_d = 1'b1;
          end else if (rx_seq == next_seq_q) begin
            state_d = StFwd;
            crc_d   = crc32_word(32'hFFFFFFFF, s_axis_phy2tlp_tdata_i);
          end else begin
            seq_err_d = 1'b1;
            state_d   = StDrop;
            if (seq_dist[11]) begin
              new_req  = 1'b1;
              new_type = 1'b0;
              new_seq  = prev_seq;
            end else if (!nak_sched_q) begin
              new_req     = 1'b1;
              new_type    = 1'b1;
              new_seq     = prev_seq;
              nak_sched_d = 1'b1;
            end
          end
        end
      end
      StFwd: begin
        if (in_fire && !s_axis_phy2tlp_tlast_i) begin
          if (hold_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_keep_d  = hold_keep_q;
            out_last_d  = 1'b0;
            out_user_d  = {hold_user_q[USER_WIDTH-1:1], 1'b0};
          end
          hold_valid_d = 1'b1;
          hold_data_d  = s_axis_phy2tlp_tdata_i;
          hold_keep_d  = s_axis_phy2tlp_tkeep_i;
          hold_user_d  = s_axis_phy2tlp_tuser_i;
          crc_d        = crc32_word(crc_q, s_axis_phy2tlp_tdata_i);
        end else if (in_fire) begin
          state_d      = StHdr;
          hold_valid_d = 1'b0;
          good_tlp     = hold_valid_q && (s_axis_phy2tlp_tdata_i == ~crc_q);
          if (hold_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_keep_d  = hold_keep_q;
            out_last_d  = 1'b1;
            out_user_d  = {hold_user_q[USER_WIDTH-1:1], !good_tlp};
          end
          if (good_tlp) begin
            next_seq_d  = next_seq_q + 12'd1;
            nak_sched_d = 1'b0;
            ack_cnt_d   = ack_cnt_d + 16'd1;
            if (ack_cnt_d >= CoalesceCnt) begin
              new_req  = 1'b1;
              new_type = 1'b0;
              new_seq  = next_seq_q;
            end
          end else begin
            lcrc_err_d = 1'b1;
            if (!nak_sched_q) begin
              new_req     = 1'b1;
              new_type    = 1'b1;
              new_seq     = prev_seq;
              nak_sched_d = 1'b1;
            end
          end
        end
      end
      StDrop: begin
        if (in_fire && s_axis_phy2tlp_tlast_i) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase

    if (req_accept) req_valid_d = 1'b0;
    // A pending NAK that is not leaving this cycle must not be replaced by an ACK.
    if (new_req && (new_type || !(req_valid_q && req_type_q && !req_accept))) begin
      req_valid_d = 1'b1;
      req_type_d  = new_type;
      req_seq_d   = new_seq;
    end

    if (!phy_link_up_i) begin
      state_d      = StHdr;
      next_seq_d   = '0;
      nak_sched_d  = 1'b0;
      crc_d        = '0;
      ack_cnt_d    = '0;
      ack_tmr_d    = '0;
      hold_valid_d = 1'b0;
      hold_data_d  = '0;
      hold_keep_d  = '0;
      hold_user_d  = '0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_keep_d   = '0;
      out_last_d   = 1'b0;
      out_user_d   = '0;
      req_valid_d  = 1'b0;
      req_type_d   = 1'b0;
      req_seq_d    = '0;
      lcrc_err_d   = 1'b0;
      seq_err_d    = 1'b0;
      s_tready     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StHdr;
      next_seq_q   <= '0;
      nak_sched_q  <= 1'b0;
      crc_q        <= '0;
      ack_cnt_q    <= '0;
      ack_tmr_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_user_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= '0;
      req_valid_q  <= 1'b0;
      req_type_q   <= 1'b0;
      req_seq_q    <= '0;
      lcrc_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_seq_q   <= next_seq_d;
      nak_sched_q  <= nak_sched_d;
      crc_q        <= crc_d;
      ack_cnt_q    <= ack_cnt_d;
      ack_tmr_q    <= ack_tmr_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_user_q  <= hold_user_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      req_valid_q  <= req_valid_d;
      req_type_q   <= req_type_d;
      req_seq_q    <= req_seq_d;
      lcrc_err_q   <= lcrc_err_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign s_axis_phy2tlp_tready_o = s_tready;
  assign m_axis_tlp_tdata_o      = out_data_q;
  assign m_axis_tlp_tkeep_o      = out_keep_q;
  assign m_axis_tlp_tvalid_o     = out_valid_q;
  assign m_axis_tlp_tlast_o      = out_last_q;
  assign m_axis_tlp_tuser_o      = out_user_q;
  assign ack_nak_valid_o         = req_valid_q;
  assign ack_nak_type_o          = req_type_q;
  assign ack_nak_seq_o           = req_seq_q;
  assign next_rcv_seq_o          = next_seq_q;
  assign lcrc_err_o              = lcrc_err_q;
  assign seq_err_o               = seq_err_q;

endmodule

// File: tb/tb_pcie_dll_rx_seq_checker.sv
// Bench for pcie_dll_rx_seq_checker: directed vector table, hand-written corner sequences and a
// randomized run checked against a frame-level model.
module tb_pcie_dll_rx_seq_checker;

  localparam int ReqSkip = 0;
  localparam int ReqAck  = 1;
  localparam int ReqNak  = 2;
  localparam int ReqNone = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_up = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = 4'hF;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [3:0]  s_tuser = '0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic [3:0]  m_tuser;
  logic        m_tready = 1'b1;
  logic        an_valid;
  logic        an_type;
  logic [11:0] an_seq;
  logic        an_ready = 1'b1;
  logic [11:0] next_seq;
  logic        lcrc_err;
  logic        seq_err;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;
  bit rand_gaps = 0;

  logic [33:0] got_q[$];   // {tuser[0], tlast, tdata}
  logic [12:0] req_q[$];   // {type, seq}
  int          lerr_cnt = 0;
  int          serr_cnt = 0;
  logic [31:0] sent_body[$];

  always #5 clk = ~clk;

  pcie_dll_rx_seq_checker #(
    .DATA_WIDTH  (32),
    .USER_WIDTH  (4),
    .ACK_COALESCE(3),
    .ACK_TIMEOUT (255)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .phy_link_up_i          (link_up),
    .s_axis_phy2tlp_tdata_i (s_tdata),
    .s_axis_phy2tlp_tkeep_i (s_tkeep),
    .s_axis_phy2tlp_tvalid_i(s_tvalid),
    .s_axis_phy2tlp_tlast_i (s_tlast),
    .s_axis_phy2tlp_tuser_i (s_tuser),
    .s_axis_phy2tlp_tready_o(s_tready),
    .m_axis_tlp_tdata_o     (m_tdata),
    .m_axis_tlp_tkeep_o     (m_tkeep),
    .m_axis_tlp_tvalid_o    (m_tvalid),
    .m_axis_tlp_tlast_o     (m_tlast),
    .m_axis_tlp_tuser_o     (m_tuser),
    .m_axis_tlp_tready_i    (m_tready),
    .ack_nak_valid_o        (an_valid),
    .ack_nak_type_o         (an_type),
    .ack_nak_seq_o          (an_seq),
    .ack_nak_ready_i        (an_ready),
    .next_rcv_seq_o         (next_seq),
    .lcrc_err_o             (lcrc_err),
    .seq_err_o              (seq_err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tuser[0], m_tlast, m_tdata});
      if (an_valid && an_ready) req_q.push_back({an_type, an_seq});
      if (lcrc_err) lerr_cnt++;
      if (seq_err) serr_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_tready = !m_tready;
      2:       m_tready = ($urandom_range(0, 2) != 0);
      default: m_tready = 1'b1;
    endcase
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference LCRC, byte by byte.
  function automatic logic [31:0] crc_beat(input logic [31:0] crc_in, input logic [31:0] w);
    logic [31:0] c;
    logic [7:0]  b;
    c = crc_in;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      c = c ^ {24'd0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic send_beat(input logic [31:0] w, input logic last);
    bit acc;
    acc = 1'b0;
    if (rand_gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = w;
    s_tlast  = last;
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_beat: tready stuck low, got 0, expected 1");
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // nbody == 0 sends a 1-beat frame (tlast on the header).
  task automatic send_frame(input logic [11:0] seq, input int nbody, input bit bad);
    logic [31:0] w;
    logic [31:0] crc;
    sent_body.delete();
    w       = $urandom();
    w[11:0] = seq;
    crc     = crc_beat(32'hFFFFFFFF, w);
    send_beat(w, nbody == 0);
    for (int i = 0; i < nbody; i++) begin
      w = $urandom();
      sent_body.push_back(w);
      crc = crc_beat(crc, w);
      send_beat(w, 1'b0);
    end
    if (nbody > 0) send_beat(~crc ^ {31'd0, bad}, 1'b1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    link_up  = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    logic [11:0] seq;
    int          nbody;
    bit          bad;
    int          exp_fwd;
    bit          exp_u0;
    logic [11:0] exp_next;
    int          exp_lerr;
    int          exp_serr;
    int          req_mode;
    logic [11:0] req_seq;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int          g0, r0, l0, s0, gpre, nlast;
    logic [33:0] b;
    logic [11:0] m_next;
    bit          m_sched;
    logic [33:0] exp_q[$];
    logic [11:0] exp_nak[$];
    logic [11:0] nak_got[$];
    int          exp_l, exp_s, kind, nb;
    logic [11:0] sq;

    vecs[0]  = '{1'b0, 12'd0, 2, 1'b0, 2, 1'b0, 12'd1, 0, 0, ReqSkip, 12'd0};
    vecs[1]  = '{1'b0, 12'd1, 2, 1'b0, 2, 1'b0, 12'd2, 0, 0, ReqSkip, 12'd0};
    vecs[2]  = '{1'b0, 12'd2, 2, 1'b0, 2, 1'b0, 12'd3, 0, 0, ReqAck, 12'd2};
    vecs[3]  = '{1'b1, 12'd0, 2, 1'b1, 2, 1'b1, 12'd0, 1, 0, ReqNak, 12'd4095};
    vecs[4]  = '{1'b0, 12'd0, 2, 1'b1, 2, 1'b1, 12'd0, 1, 0, ReqNone, 12'd0};
    vecs[5]  = '{1'b0, 12'd0, 2, 1'b0, 2, 1'b0, 12'd1, 0, 0, ReqSkip, 12'd0};
    vecs[6]  = '{1'b1, 12'd0, 2, 1'b0, 2, 1'b0, 12'd1, 0, 0, ReqSkip, 12'd0};
    vecs[7]  = '{1'b0, 12'd1, 2, 1'b0, 2, 1'b0, 12'd2, 0, 0, ReqSkip, 12'd0};
    vecs[8]  = '{1'b0, 12'd2, 2, 1'b0, 2, 1'b0, 12'd3, 0, 0, ReqAck, 12'd2};
    vecs[9]  = '{1'b0, 12'd3, 2, 1'b0, 2, 1'b0, 12'd4, 0, 0, ReqSkip, 12'd0};
    vecs[10] = '{1'b0, 12'd4, 2, 1'b0, 2, 1'b0, 12'd5, 0, 0, ReqSkip, 12'd0};
    vecs[11] = '{1'b0, 12'd3, 2, 1'b0, 0, 1'b0, 12'd5, 0, 1, ReqAck, 12'd4};
    vecs[12] = '{1'b0, 12'd7, 2, 1'b0, 0, 1'b0, 12'd5, 0, 1, ReqNak, 12'd4};
    vecs[13] = '{1'b0, 12'd7, 2, 1'b0, 0, 1'b0, 12'd5, 0, 1, ReqNone, 12'd0};
    vecs[14] = '{1'b0, 12'd5, 2, 1'b0, 2, 1'b0, 12'd6, 0, 0, ReqSkip, 12'd0};

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_tready", {31'd0, s_tready}, 32'd1);
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_an_valid", {31'd0, an_valid}, 32'd0);
    check("rst_an_seq", {20'd0, an_seq}, 32'd0);
    check("rst_next_seq", {20'd0, next_seq}, 32'd0);
    check("rst_errs", {30'd0, lcrc_err, seq_err}, 32'd0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst) do_reset();
      g0 = got_q.size();
      r0 = req_q.size();
      l0 = lerr_cnt;
      s0 = serr_cnt;
      send_frame(vecs[i].seq, vecs[i].nbody, vecs[i].bad);
      settle(8);
      check($sformatf("v%0d_fwd_count", i), got_q.size() - g0, vecs[i].exp_fwd);
      for (int j = 0; j < vecs[i].exp_fwd; j++) begin
        if (g0 + j < got_q.size()) begin
          b = got_q[g0 + j];
          check($sformatf("v%0d_beat%0d_data", i, j), b[31:0], sent_body[j]);
          check($sformatf("v%0d_beat%0d_last", i, j), {31'd0, b[32]},
                {31'd0, j == vecs[i].exp_fwd - 1});
          if (j == vecs[i].exp_fwd - 1)
            check($sformatf("v%0d_tuser0", i), {31'd0, b[33]}, {31'd0, vecs[i].exp_u0});
        end
      end
      check($sformatf("v%0d_next_seq", i), {20'd0, next_seq}, {20'd0, vecs[i].exp_next});
      check($sformatf("v%0d_lcrc_err", i), lerr_cnt - l0, vecs[i].exp_lerr);
      check($sformatf("v%0d_seq_err", i), serr_cnt - s0, vecs[i].exp_serr);
      case (vecs[i].req_mode)
        ReqAck, ReqNak: begin
          check($sformatf("v%0d_req_seen", i), {31'd0, req_q.size() > r0}, 32'd1);
          if (req_q.size() > r0)
            check($sformatf("v%0d_req", i), {19'd0, req_q[req_q.size() - 1]},
                  {19'd0, vecs[i].req_mode == ReqNak, vecs[i].req_seq});
        end
        ReqNone: check($sformatf("v%0d_no_req", i), req_q.size() - r0, 0);
        default: ;
      endcase
    end

    // Output tready toggling on a 10-beat frame.
    do_reset();
    rdy_mode = 1;
    g0 = got_q.size();
    send_frame(12'd0, 8, 1'b0);
    for (int t = 0; t < 200 && got_q.size() - g0 < 8; t++) settle(1);
    settle(6);
    rdy_mode = 0;
    check("tog_count", got_q.size() - g0, 8);
    nlast = 0;
    for (int j = 0; j < 8 && g0 + j < got_q.size(); j++) begin
      b = got_q[g0 + j];
      check($sformatf("tog_beat%0d", j), b[31:0], sent_body[j]);
      if (b[32]) nlast++;
    end
    check("tog_last_count", nlast, 1);
    check("tog_next_seq", {20'd0, next_seq}, 32'd1);

    // Reset asserted mid-FWD.
    do_reset();
    gpre = got_q.size();
    send_beat(32'hABCD_E000, 1'b0);
    for (int i = 0; i < 3; i++) send_beat($urandom(), 1'b0);
    do_reset();
    @(negedge clk);
    check("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("midrst_next_seq", {20'd0, next_seq}, 32'd0);
    nlast = 0;
    for (int j = gpre; j < got_q.size(); j++) begin
      b = got_q[j];
      if (b[32]) nlast++;
    end
    check("midrst_no_tlast", nlast, 0);
    @(posedge clk);
    #1;
    g0 = got_q.size();
    send_frame(12'd0, 2, 1'b0);
    settle(8);
    check("midrst_fwd_count", got_q.size() - g0, 2);
    if (got_q.size() - g0 == 2) begin
      b = got_q[g0 + 1];
      check("midrst_beat1", b[31:0], sent_body[1]);
      check("midrst_user0", {31'd0, b[33]}, 32'd0);
    end
    check("midrst_next_after", {20'd0, next_seq}, 32'd1);

    // Link down mid-frame behaves like reset, with tready held high.
    send_beat(32'h0000_0001, 1'b0);
    send_beat($urandom(), 1'b0);
    send_beat($urandom(), 1'b0);
    link_up = 1'b0;
    @(negedge clk);
    check("linkdn_tready", {31'd0, s_tready}, 32'd1);
    settle(2);
    @(negedge clk);
    check("linkdn_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("linkdn_next_seq", {20'd0, next_seq}, 32'd0);
    check("linkdn_an_valid", {31'd0, an_valid}, 32'd0);
    @(posedge clk);
    #1;
    link_up = 1'b1;
    send_frame(12'd0, 1, 1'b0);
    settle(6);
    check("linkup_next_seq", {20'd0, next_seq}, 32'd1);

    // Sequence wrap and timer-driven ACK.
    do_reset();
    for (int s = 0; s < 4095; s++) send_frame(12'(s), 1, 1'b0);
    settle(6);
    check("wrap_next_4095", {20'd0, next_seq}, 32'd4095);
    r0 = req_q.size();
    send_frame(12'd4095, 1, 1'b0);
    settle(6);
    check("wrap_next_0", {20'd0, next_seq}, 32'd0);
    settle(300);
    check("wrap_ack_seen", {31'd0, req_q.size() > r0}, 32'd1);
    if (req_q.size() > r0) check("wrap_ack", {19'd0, req_q[req_q.size() - 1]}, {20'd0, 12'd4095});

    // Randomized frames against a frame-level model.
    do_reset();
    rdy_mode  = 2;
    rand_gaps = 1;
    g0 = got_q.size();
    r0 = req_q.size();
    l0 = lerr_cnt;
    s0 = serr_cnt;
    m_next  = '0;
    m_sched = 1'b0;
    exp_l   = 0;
    exp_s   = 0;
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      nb   = $urandom_range(1, 5);
      if (kind <= 4 || kind == 5 || kind == 6) begin
        send_frame(m_next, nb, kind >= 5);
        for (int j = 0; j < nb; j++)
          exp_q.push_back({(kind >= 5) && (j == nb - 1), j == nb - 1, sent_body[j]});
        if (kind <= 4) begin
          m_next  = m_next + 12'd1;
          m_sched = 1'b0;
        end else begin
          exp_l++;
          if (!m_sched) begin
            exp_nak.push_back(m_next - 12'd1);
            m_sched = 1'b1;
          end
        end
      end else if (kind == 7) begin
        sq = m_next - 12'(1 + $urandom_range(0, 200));
        send_frame(sq, nb, 1'b0);
        exp_s++;
      end else if (kind == 8) begin
        sq = m_next + 12'(1 + $urandom_range(0, 200));
        send_frame(sq, nb, 1'b0);
        exp_s++;
        if (!m_sched) begin
          exp_nak.push_back(m_next - 12'd1);
          m_sched = 1'b1;
        end
      end else begin
        sq = 12'($urandom());
        send_frame(sq, 0, 1'b0);
        exp_s++;
      end
    end
    rand_gaps = 0;
    rdy_mode  = 0;
    for (int t = 0; t < 2000 && got_q.size() - g0 < exp_q.size(); t++) settle(1);
    settle(8);
    check("rnd_beat_count", got_q.size() - g0, exp_q.size());
    for (int j = 0; j < exp_q.size() && g0 + j < got_q.size(); j++)
      check($sformatf("rnd_beat%0d", j), {30'd0, got_q[g0 + j][33:32]}, {30'd0, exp_q[j][33:32]});
    for (int j = 0; j < exp_q.size() && g0 + j < got_q.size(); j++)
      if (got_q[g0 + j][31:0] !== exp_q[j][31:0])
        check($sformatf("rnd_data%0d", j), got_q[g0 + j][31:0], exp_q[j][31:0]);
    for (int j = r0; j < req_q.size(); j++) if (req_q[j][12]) nak_got.push_back(req_q[j][11:0]);
    check("rnd_nak_count", nak_got.size(), exp_nak.size());
    for (int j = 0; j < exp_nak.size() && j < nak_got.size(); j++)
      check($sformatf("rnd_nak%0d", j), {20'd0, nak_got[j]}, {20'd0, exp_nak[j]});
    check("rnd_lcrc_err", lerr_cnt - l0, exp_l);
    check("rnd_seq_err", serr_cnt - s0, exp_s);
    check("rnd_next_seq", {20'd0, next_seq}, {20'd0, m_next});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
